instr_fetch_unit: RTL

//   Consumer side of the program counter. Accepts fetch addresses from program_counter over a

---
 rtl/instr_fetch_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: takes PCs over valid/ready, issues in-order imem reads, and queues
// {instr, pc} toward decode. A flush clears the queue and marks in-flight reads for discard.
module instr_fetch_unit #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_OUT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              pc_valid,
  output logic              pc_ready,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_rvalid,
  input  logic              flush,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int TAG_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  logic [DATA_W-1:0] fifo_data_q [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];
  logic [ADDR_W-1:0] tag_q       [MAX_OUT];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TAG_W-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] inflight_q, inflight_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic [CNT_W:0] occupancy;
  logic           issue, rsp_any, rsp_drop, rsp_push, pop;

  // Tag queue depth need not be a power of two, so wrap explicitly.
  function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] p);
    return (p == TAG_W'(MAX_OUT - 1)) ? '0 : p + TAG_W'(1);
  endfunction

  // Pending drops still hold credit, so a live response always finds a free FIFO slot.
  assign occupancy   = {1'b0, count_q} + {1'b0, inflight_q};
  assign pc_ready    = !reset && !flush && (occupancy < DEPTH_C) && (inflight_q < MAX_OUT_C);
  assign issue       = pc_valid && pc_ready;
  assign imem_req    = issue;
  assign imem_addr   = pc;
  assign instr_valid = !reset && (count_q != '0);
  assign instr       = fifo_data_q[rd_ptr_q];
  assign instr_pc    = fifo_pc_q[rd_ptr_q];

  assign rsp_any  = imem_rvalid && (inflight_q != '0);
  assign rsp_drop = rsp_any && (drop_cnt_q != '0);
  assign rsp_push = rsp_any && (drop_cnt_q == '0);
  assign pop      = instr_valid && instr_ready && !flush;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through this block infers a latch.
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    tag_wr_d   = tag_wr_q;
    tag_rd_d   = tag_rd_q;
    count_d    = count_q;
    inflight_d = inflight_q;
    drop_cnt_d = drop_cnt_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      tag_wr_d   = '0;
      tag_rd_d   = '0;
      count_d    = '0;
      inflight_d = inflight_q - CNT_W'(rsp_any);
      drop_cnt_d = inflight_q - CNT_W'(rsp_any);
    end else begin
      if (issue)    tag_wr_d = tag_inc(tag_wr_q);
      if (rsp_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
        tag_rd_d = tag_inc(tag_rd_q);
      end
      if (pop)      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (rsp_drop) drop_cnt_d = drop_cnt_q - CNT_W'(1);
      inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(rsp_any);
      count_d    = count_q + CNT_W'(rsp_push) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_wr_q   <= '0;
      tag_rd_q   <= '0;
      count_q    <= '0;
      inflight_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_wr_q   <= tag_wr_d;
      tag_rd_q   <= tag_rd_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // NOTE: storage arrays are not reset; count and pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (rsp_push && !flush) begin
      fifo_data_q[wr_ptr_q] <= imem_rdata;
      fifo_pc_q[wr_ptr_q]   <= tag_q[tag_rd_q];
    end
    if (issue) tag_q[tag_wr_q] <= pc;
  end

endmodule
